// File: rtl/iobuf_pkg.sv
// Shared configuration limits for the iobuf pad-buffer bank.
package iobuf_pkg;

  localparam int unsigned IOBUF_MAX_IN_REG = 3;

endpackage

// File: rtl/iobuf_bit.sv
// Single bidirectional pad buffer: vendor IOBUF under SYNTH_XILINX, behavioural tristate otherwise.
module iobuf_bit (
  input  logic dio_i,
  output logic dio_o,
  input  logic dio_t,
  inout  wire  dio_p
);

`ifdef SYNTH_XILINX
  IOBUF u_iobuf (
    .I  (dio_i),
    .O  (dio_o),
    .T  (dio_t),
    .IO (dio_p)
  );
`else
  // dio_o is the resolved pad, so it echoes dio_i while this bit drives
  assign dio_p = dio_t ? 1'bz : dio_i;
  assign dio_o = dio_p;
`endif

endmodule

// File: rtl/iobuf_bank.sv
// Bank of bidirectional pad buffers with optional output and input pipeline registers.
module iobuf_bank
  import iobuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned IN_REG     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dio_i,
  output logic [DATA_WIDTH-1:0] dio_o,
  input  logic [DATA_WIDTH-1:0] dio_t,
  inout  wire  [DATA_WIDTH-1:0] dio_p
);

  if (IN_REG > IOBUF_MAX_IN_REG) begin : g_bad_in_reg
    $error("iobuf_bank: IN_REG=%0d outside 0..%0d", IN_REG, IOBUF_MAX_IN_REG);
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("iobuf_bank: DATA_WIDTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] pad_t;
  logic [DATA_WIDTH-1:0] pad_i;
  logic [DATA_WIDTH-1:0] pad_o;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] t_q;
    logic [DATA_WIDTH-1:0] i_q;

    // Reset releases every pad so nothing fights the board during power-up
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        t_q <= '1;
        i_q <= '0;
      end else begin
        t_q <= dio_t;
        i_q <= dio_i;
      end
    end

    assign pad_t = t_q;
    assign pad_i = i_q;
  end else begin : g_out_comb
    assign pad_t = dio_t;
    assign pad_i = dio_i;
  end

  for (genvar n = 0; n < DATA_WIDTH; n++) begin : g_bit
    iobuf_bit u_bit (
      .dio_i (pad_i[n]),
      .dio_o (pad_o[n]),
      .dio_t (pad_t[n]),
      .dio_p (dio_p[n])
    );
  end

  if (IN_REG != 0) begin : g_in_reg
    logic [DATA_WIDTH-1:0] stg_q [IN_REG];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < int'(IN_REG); s++) begin
          stg_q[s] <= '0;
        end
      end else begin
        stg_q[0] <= pad_o;
        for (int s = 1; s < int'(IN_REG); s++) begin
          stg_q[s] <= stg_q[s-1];
        end
      end
    end

    assign dio_o = stg_q[IN_REG-1];
  end else begin : g_in_comb
    assign dio_o = pad_o;
  end

  if (OUT_REG == 0 && IN_REG == 0) begin : g_no_clk
    // Purely combinational build: clock and reset are intentionally unused
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
  end

endmodule

// File: tb/tb_iobuf_bank.sv
// Self-checking bench for iobuf_bank in combinational, registered and input-pipelined builds.
module tb_iobuf_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default combinational build
  logic [7:0] t0, i0, o0, oe0, ext0;
  wire  [7:0] pad0;
  // Instance 1: OUT_REG=1, IN_REG=2
  logic [7:0] t1, i1, o1, oe1, ext1;
  wire  [7:0] pad1;
  // Instance 2: IN_REG=1
  logic [7:0] t2, i2, o2, oe2, ext2;
  wire  [7:0] pad2;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign pad0[g] = oe0[g] ? ext0[g] : 1'bz;
    assign pad1[g] = oe1[g] ? ext1[g] : 1'bz;
    assign pad2[g] = oe2[g] ? ext2[g] : 1'bz;
  end

  iobuf_bank #(.DATA_WIDTH(8), .OUT_REG(0), .IN_REG(0)) u_dut0 (
    .clk (clk), .rst (rst), .dio_i (i0), .dio_o (o0), .dio_t (t0), .dio_p (pad0)
  );
  iobuf_bank #(.DATA_WIDTH(8), .OUT_REG(1), .IN_REG(2)) u_dut1 (
    .clk (clk), .rst (rst), .dio_i (i1), .dio_o (o1), .dio_t (t1), .dio_p (pad1)
  );
  iobuf_bank #(.DATA_WIDTH(8), .OUT_REG(0), .IN_REG(1)) u_dut2 (
    .clk (clk), .rst (rst), .dio_i (i2), .dio_o (o2), .dio_t (t2), .dio_p (pad2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: a released bit shows the external value, a driven bit shows dio_i
  function automatic logic [7:0] pad_model(input logic [7:0] t, input logic [7:0] din,
                                           input logic [7:0] ext);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = t[b] ? ext[b] : din[b];
    return r;
  endfunction

  typedef struct {
    logic [7:0] t;
    logic [7:0] din;
    logic [7:0] ext;
    logic [7:0] exp_p;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vecs [6];

  logic [7:0] exp_p;
  logic [7:0] prev_t, prev_i;
  logic [7:0] pad_hist [$];
  logic       bit_t;
  logic       cyc_ok;

  initial begin
    vecs[0] = '{t: 8'hFF, din: 8'h3C, ext: 8'hA5, exp_p: 8'hA5, exp_o: 8'hA5};
    vecs[1] = '{t: 8'h00, din: 8'h5A, ext: 8'h00, exp_p: 8'h5A, exp_o: 8'h5A};
    vecs[2] = '{t: 8'hF0, din: 8'h0F, ext: 8'h90, exp_p: 8'h9F, exp_o: 8'h9F};
    vecs[3] = '{t: 8'h0F, din: 8'hA0, ext: 8'h05, exp_p: 8'hA5, exp_o: 8'hA5};
    vecs[4] = '{t: 8'hAA, din: 8'h55, ext: 8'hAA, exp_p: 8'hFF, exp_o: 8'hFF};
    vecs[5] = '{t: 8'h55, din: 8'h00, ext: 8'h00, exp_p: 8'h00, exp_o: 8'h00};

    t0 = 8'hFF; i0 = 8'h00; oe0 = 8'h00; ext0 = 8'h00;
    t1 = 8'h00; i1 = 8'h3C; oe1 = 8'hFF; ext1 = 8'h66;
    t2 = 8'hFF; i2 = 8'h00; oe2 = 8'hFF; ext2 = 8'hFF;

    // Reset state: registered pads released, pipelines cleared
    repeat (2) @(posedge clk);
    #1;
    check("rst_pad1_released", pad1, 8'h66);
    check("rst_o1_zero", o1, 8'h00);
    check("rst_o2_zero", o2, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    oe1 = 8'h00;

    // Combinational build: table vectors
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      t0 = vecs[k].t; i0 = vecs[k].din; ext0 = vecs[k].ext; oe0 = vecs[k].t;
      #1;
      check($sformatf("vec%0d_pad", k), pad0, vecs[k].exp_p);
      check($sformatf("vec%0d_o", k), o0, vecs[k].exp_o);
    end

    // Broadcast tristate, random data, 50 cycles
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bit_t = 1'($urandom_range(0, 1));
      t0 = {8{bit_t}}; oe0 = {8{bit_t}};
      i0 = 8'($urandom); ext0 = 8'($urandom);
      #1;
      exp_p  = pad_model(t0, i0, ext0);
      cyc_ok = (pad0 === exp_p) && (o0 === exp_p);
      check($sformatf("bcast%0d_pad", c), pad0, exp_p);
      check($sformatf("bcast%0d_o", c), o0, exp_p);
      if (!cyc_ok) $display("FAIL bcast%0d_pass: flag %0b, expected 1", c, cyc_ok);
    end

    // Per-bit random tristate, 30 cycles
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      t0 = 8'($urandom); oe0 = t0;
      i0 = 8'($urandom); ext0 = 8'($urandom);
      #1;
      exp_p = pad_model(t0, i0, ext0);
      check($sformatf("mixed%0d_pad", c), pad0, exp_p);
      check($sformatf("mixed%0d_o", c), o0, exp_p);
    end

    // Registered build: drive 3C, then reset mid-run
    t1 = 8'h00; i1 = 8'h3C; oe1 = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("run_pad1", pad1, 8'h3C);
    check("run_o1", o1, 8'h3C);
    @(negedge clk);
    #2;
    rst = 1'b0; oe1 = 8'hFF; ext1 = 8'h81;
    #1;
    check("midrst_pad1_released", pad1, 8'h81);
    check("midrst_o1_zero", o1, 8'h00);
    t1 = 8'hFF; i1 = 8'h00; ext1 = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Latency: pad one cycle after the input change, dio_o three cycles after
    #1;
    t1 = 8'h00; i1 = 8'hC3;
    @(posedge clk);
    #1;
    oe1 = 8'h00;
    #1;
    check("lat_pad1_c1", pad1, 8'hC3);
    check("lat_o1_c1", o1, 8'h00);
    @(posedge clk);
    #1;
    check("lat_o1_c2", o1, 8'h00);
    @(posedge clk);
    #1;
    check("lat_o1_c3", o1, 8'hC3);

    // Registered build, random traffic; bench drives exactly where the registered tristate releases
    prev_t = 8'h00; prev_i = 8'hC3;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      oe1  = prev_t;
      ext1 = 8'($urandom);
      exp_p = pad_model(prev_t, prev_i, ext1);
      t1 = 8'($urandom); i1 = 8'($urandom);
      prev_t = t1; prev_i = i1;
      #1;
      check($sformatf("reg%0d_pad", c), pad1, exp_p);
      if (pad_hist.size() >= 2) check($sformatf("reg%0d_o", c), o1, pad_hist[pad_hist.size()-2]);
      pad_hist.push_back(exp_p);
    end

    // IN_REG=1: pad change just after a posedge appears only at the next posedge
    t2 = 8'hFF; oe2 = 8'hFF; ext2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("inreg1_base", o2, 8'h00);
    ext2 = 8'hFF;
    #1;
    check("inreg1_hold", o2, 8'h00);
    @(negedge clk);
    check("inreg1_hold_neg", o2, 8'h00);
    @(posedge clk);
    #1;
    check("inreg1_update", o2, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
